// File: rtl/phase_accumulator.sv
// NCO phase accumulator: sums an FTW modulo 2^PHASE_WIDTH, adds a static offset and accepts FTW updates immediately or at the next wrap.
// Defining PHASE_DITHER_EN adds LFSR dither to the phase LSBs. The accumulator and wrap are not dithered.
module phase_accumulator #(
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DITHER_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   clear,
  input  logic                   sync_mode,
  input  logic [PHASE_WIDTH-1:0] ftw_data,
  input  logic                   ftw_valid,
  output logic                   ftw_ready,
  input  logic [PHASE_WIDTH-1:0] phase_offset,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic                   phase_valid,
  output logic                   wrap
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t                 state, state_next;
  logic [PHASE_WIDTH-1:0] acc, acc_next;
  logic [PHASE_WIDTH-1:0] ftw_active, ftw_active_next;
  logic [PHASE_WIDTH-1:0] ftw_pending, ftw_pending_next;
  logic [PHASE_WIDTH:0]   sum;
  logic                   step, carry, transfer;
  logic [PHASE_WIDTH-1:0] dither;

  // Dither must stay below the LUT address bits, and it cannot be wider than the 16-bit LFSR.
  if (DITHER_BITS < 1 || DITHER_BITS > 16 || DITHER_BITS > PHASE_WIDTH - ADDR_WIDTH) begin : g_bad_dither_cfg
    $error("phase_accumulator: DITHER_BITS out of range");
  end

  always_comb begin
    step  = enable & ~clear;
    sum   = {1'b0, acc} + {1'b0, ftw_active};
    carry = step & sum[PHASE_WIDTH];
    if (clear)
      acc_next = '0;
    else if (enable)
      acc_next = sum[PHASE_WIDTH-1:0];
    else
      acc_next = acc;
  end

  assign ftw_ready = (state == IDLE);
  assign transfer  = ftw_valid & ftw_ready;

  // A pending word takes effect after a wrap, after a clear, or when sync_mode is dropped.
  always_comb begin
    state_next       = state;
    ftw_active_next  = ftw_active;
    ftw_pending_next = ftw_pending;
    case (state)
      IDLE: begin
        if (transfer) begin
          if (sync_mode) begin
            ftw_pending_next = ftw_data;
            state_next       = PENDING;
          end else begin
            ftw_active_next = ftw_data;
          end
        end
      end
      PENDING: begin
        if (carry || clear || !sync_mode) begin
          ftw_active_next = ftw_pending;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef PHASE_DITHER_EN
  logic [15:0] lfsr;

  // Galois LFSR for x^16+x^14+x^13+x^11+1. It advances only on enabled steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr <= 16'hACE1;
    else if (step)
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign dither = {{(PHASE_WIDTH-DITHER_BITS){1'b0}}, lfsr[DITHER_BITS-1:0]};
`else
  assign dither = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      ftw_active  <= '0;
      ftw_pending <= '0;
      phase       <= '0;
      phase_valid <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      state       <= state_next;
      acc         <= acc_next;
      ftw_active  <= ftw_active_next;
      ftw_pending <= ftw_pending_next;
      phase       <= acc_next + phase_offset + dither;
      phase_valid <= step;
      wrap        <= carry;
    end
  end

endmodule

// File: tb/tb_phase_accumulator.sv
// Self-checking bench for phase_accumulator. A behavioural model is compared every cycle.
// Directed vectors carry hand-computed phase, valid, wrap and ready values.
module tb_phase_accumulator;
  localparam int PW = 32;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          enable = 1'b0, clear = 1'b0, sync_mode = 1'b0, ftw_valid = 1'b0;
  logic [PW-1:0] ftw_data = '0, phase_offset = '0;
  logic          ftw_ready, phase_valid, wrap;
  logic [PW-1:0] phase;

  int total = 0;
  int bad   = 0;
  int wraps = 0;

  phase_accumulator #(.PHASE_WIDTH(PW), .ADDR_WIDTH(8), .DITHER_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .sync_mode(sync_mode),
    .ftw_data(ftw_data), .ftw_valid(ftw_valid), .ftw_ready(ftw_ready),
    .phase_offset(phase_offset), .phase(phase), .phase_valid(phase_valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // The model adds with 64-bit arithmetic. A wrap is any sum that reaches 2^PW.
  logic [PW-1:0]   m_acc = '0, m_ftw = '0, m_held = '0, m_phase = '0, m_next;
  logic            m_waiting = 1'b0, m_valid = 1'b0, m_wrap = 1'b0, m_carry;
  longint unsigned m_raw;

  always_comb begin
    m_raw   = 64'(m_acc) + 64'(m_ftw);
    m_carry = enable && !clear && ((m_raw >> PW) != 0);
    m_next  = clear ? '0 : (enable ? PW'(m_raw) : m_acc);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc <= '0; m_ftw <= '0; m_held <= '0; m_waiting <= 1'b0;
      m_phase <= '0; m_valid <= 1'b0; m_wrap <= 1'b0;
    end else begin
      m_acc   <= m_next;
      m_phase <= m_next + phase_offset;
      m_valid <= enable && !clear;
      m_wrap  <= m_carry;
      if (!m_waiting) begin
        if (ftw_valid && sync_mode) begin
          m_held    <= ftw_data;
          m_waiting <= 1'b1;
        end else if (ftw_valid) begin
          m_ftw <= ftw_data;
        end
      end else if (m_carry || clear || !sync_mode) begin
        m_ftw     <= m_held;
        m_waiting <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [PW-1:0] actual, input logic [PW-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, clr, sm, fv, input logic [PW-1:0] fd, off);
    @(negedge clk);
    enable = en; clear = clr; sync_mode = sm; ftw_valid = fv; ftw_data = fd; phase_offset = off;
  endtask

  task automatic stepCheck(input string name, input logic en, clr, sm, fv, input logic [PW-1:0] fd, off,
                           input logic [PW-1:0] exp_phase, input logic exp_valid, exp_wrap, exp_ready);
    applyStimulus(en, clr, sm, fv, fd, off);
    @(posedge clk); #1;
    checkOutput({name, " phase"}, phase, exp_phase);
    checkOutput({name, " valid"}, {31'b0, phase_valid}, {31'b0, exp_valid});
    checkOutput({name, " wrap"}, {31'b0, wrap}, {31'b0, exp_wrap});
    checkOutput({name, " ready"}, {31'b0, ftw_ready}, {31'b0, exp_ready});
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk); #1;
        if (rst_n) begin
          checkOutput("model phase", phase, m_phase);
          checkOutput("model valid", {31'b0, phase_valid}, {31'b0, m_valid});
          checkOutput("model wrap", {31'b0, wrap}, {31'b0, m_wrap});
          checkOutput("model ready", {31'b0, ftw_ready}, {31'b0, !m_waiting});
        end
      end
    join_none

    $display("[TB] reset");
    repeat (2) @(negedge clk);
    checkOutput("reset phase", phase, '0);
    checkOutput("reset valid", {31'b0, phase_valid}, '0);
    checkOutput("reset wrap", {31'b0, wrap}, '0);
    checkOutput("reset ready", {31'b0, ftw_ready}, 32'd1);
    rst_n = 1'b1;

    $display("[TB] test 1: FTW 0x01000000, 256 steps");
    stepCheck("t1 load", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0100_0000, '0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int k = 1; k <= 256; k++) begin
      @(posedge clk); #1;
      checkOutput("t1 phase", phase, PW'(k) << 24);
      if (wrap) wraps++;
      if (k == 256) checkOutput("t1 wrap at 256", {31'b0, wrap}, 32'd1);
    end
    checkOutput("t1 wrap count", PW'(wraps), 32'd1);

    $display("[TB] test 2: FTW 0x80000000");
    stepCheck("t2 load", 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, '0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++)
      stepCheck("t2 step", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0,
                (k % 2 == 1) ? 32'h8000_0000 : 32'h0, 1'b1, (k % 2 == 0), 1'b1);

    $display("[TB] test 3: phase-coherent update");
    stepCheck("t3 load", 1'b0, 1'b0, 1'b0, 1'b1, 32'h4000_0000, '0, 32'h0, 1'b0, 1'b0, 1'b1);
    stepCheck("t3 s1", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 32'h4000_0000, 1'b1, 1'b0, 1'b1);
    stepCheck("t3 send", 1'b1, 1'b0, 1'b1, 1'b1, 32'h1000_0000, '0, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    stepCheck("t3 s3", 1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 32'hC000_0000, 1'b1, 1'b0, 1'b0);
    stepCheck("t3 wrap", 1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
    stepCheck("t3 new1", 1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 32'h1000_0000, 1'b1, 1'b0, 1'b1);
    stepCheck("t3 new2", 1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 32'h2000_0000, 1'b1, 1'b0, 1'b1);

    $display("[TB] test 4: FTW 0 with offset");
    stepCheck("t4 load", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++)
      stepCheck("t4 run", 1'b1, 1'b0, 1'b0, 1'b0, '0, 32'h4000_0000, 32'h4000_0000, 1'b1, 1'b0, 1'b1);
    stepCheck("t4 hold", 1'b0, 1'b0, 1'b0, 1'b0, '0, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b1);

    $display("[TB] test 5: clear with pending FTW, sync_mode drop");
    stepCheck("t5 load", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0100_0000, 32'h100, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
    stepCheck("t5 s1", 1'b1, 1'b0, 1'b0, 1'b0, '0, 32'h100, 32'h0100_0100, 1'b1, 1'b0, 1'b1);
    stepCheck("t5 send", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0080_0000, 32'h100, 32'h0200_0100, 1'b1, 1'b0, 1'b0);
    stepCheck("t5 s3", 1'b1, 1'b0, 1'b1, 1'b0, '0, 32'h100, 32'h0300_0100, 1'b1, 1'b0, 1'b0);
    stepCheck("t5 clear", 1'b1, 1'b1, 1'b1, 1'b0, '0, 32'h100, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
    stepCheck("t5 n1", 1'b1, 1'b0, 1'b1, 1'b0, '0, 32'h100, 32'h0080_0100, 1'b1, 1'b0, 1'b1);
    stepCheck("t5 n2", 1'b1, 1'b0, 1'b1, 1'b0, '0, 32'h100, 32'h0100_0100, 1'b1, 1'b0, 1'b1);
    stepCheck("t5 send2", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0000, 32'h100, 32'h0100_0100, 1'b0, 1'b0, 1'b0);
    stepCheck("t5 idle", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0000, 32'h100, 32'h0100_0100, 1'b0, 1'b0, 1'b0);
    stepCheck("t5 drop", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0000, 32'h100, 32'h0100_0100, 1'b0, 1'b0, 1'b1);
    stepCheck("t5 n3", 1'b1, 1'b0, 1'b0, 1'b0, '0, 32'h100, 32'h0140_0100, 1'b1, 1'b0, 1'b1);

    $display("[TB] test 6: asynchronous reset mid-run");
    stepCheck("t6 run", 1'b1, 1'b0, 1'b0, 1'b0, '0, 32'h100, 32'h0180_0100, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkOutput("t6 async phase", phase, '0);
    checkOutput("t6 async valid", {31'b0, phase_valid}, '0);
    checkOutput("t6 async wrap", {31'b0, wrap}, '0);
    checkOutput("t6 async ready", {31'b0, ftw_ready}, 32'd1);
    repeat (2) @(negedge clk);
    enable = 1'b1; clear = 1'b0; sync_mode = 1'b0; ftw_valid = 1'b0; ftw_data = '0; phase_offset = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("t6 restart phase", phase, '0);
    checkOutput("t6 restart valid", {31'b0, phase_valid}, 32'd1);
    checkOutput("t6 restart ready", {31'b0, ftw_ready}, 32'd1);
    stepCheck("t6 load", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0001_0000, '0, 32'h0, 1'b1, 1'b0, 1'b1);
    stepCheck("t6 s1", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 32'h0001_0000, 1'b1, 1'b0, 1'b1);
    stepCheck("t6 s2", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 32'h0002_0000, 1'b1, 1'b0, 1'b1);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
